// File: rtl/xmod_pkg.sv
// Shared types and elaboration-time helpers for the sequential X mod MOD engine.
// Optional early-exit build is selected with XMOD_EARLY_EXIT_EN (see x_mod_m_seq).
package xmod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to index v values (ceil(log2(v))), 0 for v <= 1.
    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned     r;
        longint unsigned p;
        r = 0;
        p = 64'd1;
        while (p < v) begin
            p = p << 1;
            r = r + 32'd1;
        end
        return r;
    endfunction

    function automatic int unsigned pow2_mod(input int unsigned e, input int unsigned m);
        int unsigned r;
        r = 32'd1 % m;
        for (int unsigned i = 0; i < e; i++) begin
            r = (r * 32'd2) % m;
        end
        return r;
    endfunction

    // Weight of entry idx in a table of powers 2**(idx*step) mod m.
    function automatic int unsigned gen_weight(input int unsigned idx, input int unsigned step,
                                               input int unsigned m);
        return pow2_mod(idx * step, m);
    endfunction

    // Largest value one fold pass can produce from an in_w-bit input.
    function automatic longint unsigned fold_bound(input int unsigned in_w, input int unsigned r_w,
                                                   input int unsigned m);
        longint unsigned lo;
        lo = (64'd1 << r_w) - 64'd1;
        if (in_w <= r_w) begin
            return lo;
        end
        return lo + 64'(in_w - r_w) * (64'(m) - 64'd1);
    endfunction

    // Largest acc*W + sum(chunk_i*w_i) seen in one Horner step.
    function automatic longint unsigned horner_bound(input int unsigned m, input int unsigned chunk_w,
                                                     input int unsigned cpc);
        longint unsigned mm;
        mm = 64'(m) - 64'd1;
        return mm * mm + 64'(cpc) * ((64'd1 << chunk_w) - 64'd1) * mm;
    endfunction

endpackage

// File: rtl/x_mod_m_fold.sv
// Combinational exact reduction of a wide sum into [0, MOD): two high-bit folding
// passes with constant weights 2**k mod MOD, then a short chain of conditional subtracts.
module xmod_fold
    import xmod_pkg::*;
#(
    parameter int unsigned IN_SUM_W = 14,
    parameter int unsigned MOD      = 47,
    localparam int unsigned R_W     = clog2(64'(MOD))
) (
    input  logic [IN_SUM_W-1:0] sum,
    output logic [R_W-1:0]      res_c
);

    localparam int unsigned S1_W  = clog2(fold_bound(IN_SUM_W, R_W, MOD) + 64'd1);
    localparam int unsigned S2_W  = clog2(fold_bound(S1_W, R_W, MOD) + 64'd1);
    localparam int unsigned N_SUB = 32'(fold_bound(S1_W, R_W, MOD) / 64'(MOD));

    logic [S1_W-1:0] s1;
    logic [S2_W-1:0] s2;

    always_comb begin
        s1 = S1_W'(sum[R_W-1:0]);
        for (int unsigned k = R_W; k < IN_SUM_W; k++) begin
            if (sum[k]) s1 = s1 + S1_W'(pow2_mod(k, MOD));
        end
        s2 = S2_W'(s1[R_W-1:0]);
        for (int unsigned k = R_W; k < S1_W; k++) begin
            if (s1[k]) s2 = s2 + S2_W'(pow2_mod(k, MOD));
        end
        // Residual is bounded by N_SUB*MOD + MOD-1, so N_SUB subtracts make it exact.
        for (int unsigned j = 0; j < N_SUB; j++) begin
            if (s2 >= S2_W'(MOD)) s2 = s2 - S2_W'(MOD);
        end
    end

    assign res_c = R_W'(s2);

endmodule

// File: rtl/x_mod_m_seq.sv
// Multi-cycle residue engine R = X mod MOD, MSB-first Horner over BEAT_W-bit beats.
// Define XMOD_EARLY_EXIT_EN to start at the highest nonzero beat instead of a fixed latency.
module x_mod_m_seq
    import xmod_pkg::*;
#(
    parameter int unsigned IN_W    = 200,
    parameter int unsigned MOD     = 47,
    parameter int unsigned CHUNK_W = 6,
    parameter int unsigned CPC     = 4,
    localparam int unsigned R_W    = clog2(64'(MOD))
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [R_W-1:0]  out_r,
    output logic            busy
);

    localparam int unsigned BEAT_W  = CHUNK_W * CPC;
    localparam int unsigned N_BEATS = (IN_W + BEAT_W - 1) / BEAT_W;
    localparam int unsigned PAD_W   = N_BEATS * BEAT_W;
    localparam int unsigned CNT_W   = (N_BEATS > 1) ? clog2(64'(N_BEATS)) : 1;
    localparam int unsigned BEAT_WT = pow2_mod(BEAT_W, MOD);
    localparam int unsigned SUM_W   = clog2(horner_bound(MOD, CHUNK_W, CPC) + 64'd1);

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [PAD_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [R_W-1:0]     acc_q, acc_d;
    logic [PAD_W-1:0]   pad_c;
    logic [SUM_W-1:0]   sum_c;
    logic [R_W-1:0]     fold_c;
    logic               accept_c;

    assign accept_c = in_valid && in_ready_q;
    assign pad_c    = PAD_W'(in_x);

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = RUN;
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in flops alongside it.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
        case (state_d)
            IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            DONE:    out_valid_d = 1'b1;
            default: ;
        endcase
    end

`ifdef XMOD_EARLY_EXIT_EN
    logic [CNT_W-1:0] top_beat_c;

    always_comb begin
        top_beat_c = '0;
        for (int unsigned j = 0; j < N_BEATS; j++) begin
            if (pad_c[j*BEAT_W +: BEAT_W] != '0) top_beat_c = CNT_W'(j);
        end
    end
`endif

    // One Horner step on the top beat of the shift register.
    always_comb begin
        sum_c = SUM_W'(acc_q) * SUM_W'(BEAT_WT);
        for (int unsigned i = 0; i < CPC; i++) begin
            sum_c = sum_c + SUM_W'(sh_q[PAD_W-BEAT_W+CHUNK_W*i +: CHUNK_W])
                          * SUM_W'(gen_weight(i, CHUNK_W, MOD));
        end
    end

    xmod_fold #(
        .IN_SUM_W (SUM_W),
        .MOD      (MOD)
    ) u_fold (
        .sum   (sum_c),
        .res_c (fold_c)
    );

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (accept_c) begin
            acc_d = '0;
`ifdef XMOD_EARLY_EXIT_EN
            cnt_d = top_beat_c;
            sh_d  = pad_c;
            for (int unsigned j = 0; j < N_BEATS; j++) begin
                if (top_beat_c == CNT_W'(j)) sh_d = pad_c << (BEAT_W * (N_BEATS - 1 - j));
            end
`else
            cnt_d = CNT_W'(N_BEATS - 1);
            sh_d  = pad_c;
`endif
        end else if (state_q == RUN) begin
            acc_d = fold_c;
            sh_d  = sh_q << BEAT_W;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_r     = acc_q;

endmodule

// File: tb/tb_x_mod_m_seq.sv
// Directed and randomised checks of x_mod_m_seq at default parameters (MOD=47).
module tb_x_mod_m_seq;

    localparam int unsigned IN_W    = 200;
    localparam int unsigned R_W     = 6;
    localparam int unsigned N_BEATS = 9;
    localparam int          TMO     = 50;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IN_W-1:0] in_x = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [R_W-1:0]  out_r;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    x_mod_m_seq #(
        .IN_W    (200),
        .MOD     (47),
        .CHUNK_W (6),
        .CPC     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_mod(input logic [IN_W-1:0] x);
        int unsigned r;
        r = 0;
        for (int i = IN_W - 1; i >= 0; i--) r = (r * 32'd2 + 32'(x[i])) % 32'd47;
        return r;
    endfunction

    // Expected latency: early-exit value when that build is selected, N_BEATS otherwise.
    function automatic int lat_of(input int early);
`ifdef XMOD_EARLY_EXIT_EN
        return early;
`else
        return (early >= 0) ? int'(N_BEATS) : -1;
`endif
    endfunction

    // Offer x, wait (bounded) for the result, check it and latency, then drain.
    task automatic run_op(input string tag, input logic [IN_W-1:0] x,
                          input int unsigned exp_r, input int exp_lat);
        int cyc;
        cyc = 0;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_x     = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x     = '0;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        while (!out_valid && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        if (exp_lat >= 0) check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, ".out_r"}, 64'(out_r), 64'(exp_r));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".drain"}, 64'({in_ready, out_valid, busy}), 64'b100);
    endtask

    initial begin
        logic [IN_W-1:0] x;
        logic [223:0]    t;
        int              cyc;

        #2 rst_n = 1'b0;
        #1;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.out_r", 64'(out_r), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("x0", '0, 0, lat_of(1));
        run_op("x47", IN_W'(47), 0, lat_of(1));
        run_op("x46", IN_W'(46), 46, lat_of(1));
        run_op("x48", IN_W'(48), 1, lat_of(1));
        run_op("ones", '1, 17, lat_of(9));
        x = '0; x[199] = 1'b1;
        run_op("p199", x, 9, lat_of(9));
        x = '0; x[24] = 1'b1;
        run_op("p24", x, 2, lat_of(2));
        x = '0; x[100] = 1'b1;
        run_op("p100", x, 21, lat_of(5));

        // Result held under backpressure while a second operand is offered.
        in_x = IN_W'(46); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp.out_valid", 64'(out_valid), 64'd1);
        in_x = IN_W'(48); in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.hold", 64'({out_valid, in_ready, busy}), 64'b101);
            check("bp.out_r", 64'(out_r), 64'd46);
        end
        in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.release", 64'({in_ready, out_valid, busy}), 64'b100);
        run_op("bp.next", IN_W'(48), 1, lat_of(1));

        // Asynchronous abort in the middle of a run.
        in_x = '1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_x = '0;
        repeat (4) begin @(posedge clk); #1; end
        check("rst.pre_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst.abort", 64'({out_valid, in_ready, busy}), 64'b010);
        check("rst.out_r", 64'(out_r), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("rst.next", '1, 17, lat_of(9));

        for (int n = 0; n < 300; n++) begin
            for (int w = 0; w < 7; w++) t[w*32 +: 32] = $urandom();
            x = t[IN_W-1:0];
            x = x >> $urandom_range(0, IN_W - 1);
            run_op("rand", x, ref_mod(x), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
